// File: rtl/noc_credit_tracker.sv
// noc_credit_tracker: per-VC credit counters for a NoC router output port.
// Each VC owns one saturating counter that mirrors the free slots of the
// downstream input buffer. Outputs are decoded from registers only.
// Optional feature macro: NOC_CC_ERR_CHECK_EN adds sticky overflow/underflow
// flags. When it is undefined, the error outputs are tied low and err_clr_i
// is ignored.

module noc_credit_tracker_vc #(
   parameter int DEPTH = 5,
   parameter int INIT  = DEPTH,
   parameter int CNT_W = $clog2(DEPTH+1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             dec_i,
   input  logic             inc_i,
   input  logic             err_clr_i,
   output logic [CNT_W-1:0] count_o,
   output logic             ovf_o,
   output logic             unf_o
);
   localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] INIT_C = CNT_W'(INIT);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_evt, unf_evt;

   // Next count: a lone inc or dec moves the count; saturation raises an event.
   // inc and dec together are a net hold and never an error.
   always_comb begin
      cnt_d   = cnt_q;
      ovf_evt = 1'b0;
      unf_evt = 1'b0;
      if (inc_i && !dec_i) begin
         if (cnt_q == MAX_C) ovf_evt = 1'b1;
         else                cnt_d   = cnt_q + 1'b1;
      end else if (dec_i && !inc_i) begin
         if (cnt_q == '0)    unf_evt = 1'b1;
         else                cnt_d   = cnt_q - 1'b1;
      end
   end

   // Count register; reset discards any in-flight update.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= INIT_C;
      else       cnt_q <= cnt_d;
   end

   assign count_o = cnt_q;

`ifdef NOC_CC_ERR_CHECK_EN
   logic ovf_q, ovf_d, unf_q, unf_d;

   // Sticky flags: a new event beats a simultaneous clear.
   always_comb begin
      ovf_d = ovf_evt | (ovf_q & ~err_clr_i);
      unf_d = unf_evt | (unf_q & ~err_clr_i);
   end

   // Flag registers share the count's edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign ovf_o = ovf_q;
   assign unf_o = unf_q;
`else
   logic unused_err;
   assign unused_err = ^{err_clr_i, ovf_evt, unf_evt};
   assign ovf_o      = 1'b0;
   assign unf_o      = 1'b0;
`endif

endmodule

module noc_credit_tracker #(
   parameter int NUM_VC = 2,
   parameter int DEPTH  = 5,
   parameter int INIT   = DEPTH,
   parameter int CNT_W  = $clog2(DEPTH+1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_VC-1:0]       dec_i,
   input  logic [NUM_VC-1:0]       inc_i,
   output logic [NUM_VC-1:0]       credit_o,
   output logic [NUM_VC*CNT_W-1:0] count_o,
   output logic                    drained_o,
   input  logic                    err_clr_i,
   output logic [NUM_VC-1:0]       err_ovf_o,
   output logic [NUM_VC-1:0]       err_unf_o
);
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(DEPTH);

   logic [NUM_VC-1:0][CNT_W-1:0] cnt;
   logic [NUM_VC-1:0]            full;

   for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
      noc_credit_tracker_vc #(
         .DEPTH (DEPTH),
         .INIT  (INIT),
         .CNT_W (CNT_W)
      ) u_vc (
         .clk       (clk),
         .reset     (reset),
         .dec_i     (dec_i[v]),
         .inc_i     (inc_i[v]),
         .err_clr_i (err_clr_i),
         .count_o   (cnt[v]),
         .ovf_o     (err_ovf_o[v]),
         .unf_o     (err_unf_o[v])
      );

      assign count_o[v*CNT_W +: CNT_W] = cnt[v];
      assign credit_o[v]               = |cnt[v];
      assign full[v]                   = (cnt[v] == MAX_C);
   end

   assign drained_o = &full;

endmodule

// File: tb/tb_noc_credit_tracker.sv
// Directed, table-driven bench for noc_credit_tracker (NUM_VC=2, DEPTH=5,
// INIT=5). Expected error flags follow NOC_CC_ERR_CHECK_EN.
module tb_noc_credit_tracker;
   localparam int NUM_VC = 2;
   localparam int DEPTH  = 5;
   localparam int CNT_W  = 3;
`ifdef NOC_CC_ERR_CHECK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic                    clk = 1'b0;
   logic                    reset;
   logic [NUM_VC-1:0]       dec_i, inc_i;
   logic                    err_clr_i;
   logic [NUM_VC-1:0]       credit_o;
   logic [NUM_VC*CNT_W-1:0] count_o;
   logic                    drained_o;
   logic [NUM_VC-1:0]       err_ovf_o, err_unf_o;

   int n_chk = 0;
   int n_err = 0;

   noc_credit_tracker #(.NUM_VC(NUM_VC), .DEPTH(DEPTH), .INIT(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .dec_i     (dec_i),
      .inc_i     (inc_i),
      .credit_o  (credit_o),
      .count_o   (count_o),
      .drained_o (drained_o),
      .err_clr_i (err_clr_i),
      .err_ovf_o (err_ovf_o),
      .err_unf_o (err_unf_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] dec;
      logic [1:0] inc;
      logic       clr;
      int         c0;
      int         c1;
      logic [1:0] cred;
      logic       drn;
      logic [1:0] ovf;
      logic [1:0] unf;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic [1:0] dec, logic [1:0] inc, logic clr,
                               int c0, int c1, logic [1:0] cred, logic drn,
                               logic [1:0] ovf, logic [1:0] unf);
      vec_t r;
      r.dec = dec; r.inc = inc; r.clr = clr; r.c0 = c0; r.c1 = c1;
      r.cred = cred; r.drn = drn; r.ovf = ovf; r.unf = unf;
      return r;
   endfunction

   task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic chk_all(int idx, int c0, int c1, logic [1:0] cred, logic drn,
                          logic [1:0] ovf, logic [1:0] unf);
      logic [5:0] exp_cnt;
      exp_cnt = {3'(c1), 3'(c0)};
      chk("count", idx, 32'(count_o), 32'(exp_cnt));
      chk("credit", idx, 32'(credit_o), 32'(cred));
      chk("drained", idx, 32'(drained_o), 32'(drn));
      chk("err_ovf", idx, 32'(err_ovf_o), ERR_EN ? 32'(ovf) : 32'd0);
      chk("err_unf", idx, 32'(err_unf_o), ERR_EN ? 32'(unf) : 32'd0);
   endtask

   task automatic step(logic [1:0] dec, logic [1:0] inc, logic clr);
      dec_i = dec; inc_i = inc; err_clr_i = clr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      //             dec    inc    clr  c0 c1 cred   drn  ovf    unf
      tbl.push_back(mk(2'b00, 2'b00, 0, 5, 5, 2'b11, 1, 2'b00, 2'b00)); // idle
      tbl.push_back(mk(2'b01, 2'b00, 0, 4, 5, 2'b11, 0, 2'b00, 2'b00));
      tbl.push_back(mk(2'b01, 2'b00, 0, 3, 5, 2'b11, 0, 2'b00, 2'b00));
      tbl.push_back(mk(2'b01, 2'b00, 0, 2, 5, 2'b11, 0, 2'b00, 2'b00));
      tbl.push_back(mk(2'b01, 2'b00, 0, 1, 5, 2'b11, 0, 2'b00, 2'b00));
      tbl.push_back(mk(2'b01, 2'b00, 0, 0, 5, 2'b10, 0, 2'b00, 2'b00)); // empty
      tbl.push_back(mk(2'b01, 2'b00, 0, 0, 5, 2'b10, 0, 2'b00, 2'b01)); // underflow
      tbl.push_back(mk(2'b00, 2'b00, 1, 0, 5, 2'b10, 0, 2'b00, 2'b00)); // clear
      tbl.push_back(mk(2'b00, 2'b10, 0, 0, 5, 2'b10, 0, 2'b10, 2'b00)); // overflow
      tbl.push_back(mk(2'b01, 2'b01, 0, 0, 5, 2'b10, 0, 2'b10, 2'b00)); // both @0
      tbl.push_back(mk(2'b00, 2'b10, 1, 0, 5, 2'b10, 0, 2'b10, 2'b00)); // set wins
      tbl.push_back(mk(2'b00, 2'b00, 1, 0, 5, 2'b10, 0, 2'b00, 2'b00));
      tbl.push_back(mk(2'b00, 2'b01, 0, 1, 5, 2'b11, 0, 2'b00, 2'b00));
      tbl.push_back(mk(2'b00, 2'b01, 0, 2, 5, 2'b11, 0, 2'b00, 2'b00));
      tbl.push_back(mk(2'b00, 2'b01, 0, 3, 5, 2'b11, 0, 2'b00, 2'b00));
      tbl.push_back(mk(2'b01, 2'b01, 0, 3, 5, 2'b11, 0, 2'b00, 2'b00)); // both @3
      tbl.push_back(mk(2'b11, 2'b00, 0, 2, 4, 2'b11, 0, 2'b00, 2'b00));
      tbl.push_back(mk(2'b01, 2'b10, 0, 1, 5, 2'b11, 0, 2'b00, 2'b00));
      tbl.push_back(mk(2'b11, 2'b11, 0, 1, 5, 2'b11, 0, 2'b00, 2'b00));
      tbl.push_back(mk(2'b00, 2'b01, 0, 2, 5, 2'b11, 0, 2'b00, 2'b00));
      tbl.push_back(mk(2'b00, 2'b10, 0, 2, 5, 2'b11, 0, 2'b10, 2'b00)); // err before reset

      reset = 1'b1; dec_i = '0; inc_i = '0; err_clr_i = 1'b0;
      #2;
      chk_all(-1, 5, 5, 2'b11, 1'b1, 2'b00, 2'b00);  // asynchronous reset state
      @(posedge clk); #1;
      reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].dec, tbl[i].inc, tbl[i].clr);
         chk_all(i, tbl[i].c0, tbl[i].c1, tbl[i].cred, tbl[i].drn,
                 tbl[i].ovf, tbl[i].unf);
      end

      // Mid-cycle reset with VC0 at 2 and a dec pending: outputs restore
      // immediately, and the pending dec is never applied.
      dec_i = 2'b01; inc_i = 2'b00; err_clr_i = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk_all(100, 5, 5, 2'b11, 1'b1, 2'b00, 2'b00);
      @(posedge clk); #1;
      chk_all(101, 5, 5, 2'b11, 1'b1, 2'b00, 2'b00);
      dec_i = 2'b00;
      reset = 1'b0;
      step(2'b00, 2'b00, 1'b0);
      chk_all(102, 5, 5, 2'b11, 1'b1, 2'b00, 2'b00);

      // Underflow on VC1 only after draining it fully.
      for (int k = 0; k < 5; k++) step(2'b10, 2'b00, 1'b0);
      chk_all(103, 5, 0, 2'b01, 1'b0, 2'b00, 2'b00);
      step(2'b10, 2'b00, 1'b0);
      chk_all(104, 5, 0, 2'b01, 1'b0, 2'b00, 2'b10);
      step(2'b00, 2'b00, 1'b0);
      chk_all(105, 5, 0, 2'b01, 1'b0, 2'b00, 2'b10);  // sticky

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
